bram_reader_2in_split: RTL and testbench
========================================

Name: bram_reader_2in_split

Overview:
- Reads one full decimated frame from the selected ping-pong BRAM and splits each stored word into two independent AXI-style streams.
- Stream A carries disp+conf (upper field); stream B carries grayscale (lower field).
- It is the read-side counterpart of the two-input BRAM writer, used to replay stored frames to downstream consumers (debug/host readback, refiltering).
- Controlled by the same start/index/idle handshake as the other BRAM movers in the filter subsystem.

Parameters:
- width, 120, frame width in pixels
- height, 240, frame height in pixels
- a_width, 13, stream A field width (8 + disp_bits); occupies word[a_width+b_width-1:b_width]
- b_width, 8, stream B field width; occupies word[b_width-1:0]
- addr_w, $clog2(width*height), BRAM address width (derived localparam)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin one frame read (sampled only in IDLE)
- bram_index_in  in  1  BRAM bank to read for this frame
- idle  out  1  high when no frame in progress
- rd_bram_index  out  1  latched bank index driven to the read-port mux
- rd_address  out  addr_w  BRAM read address
- rd_data  in  a_width+b_width  BRAM read data, valid 1 cycle after rd_address
- a_data  out  a_width  stream A payload
- a_valid  out  1  stream A valid
- a_ready  in  1  stream A ready
- b_data  out  b_width  stream B payload
- b_valid  out  1  stream B valid
- b_ready  in  1  stream B ready

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, idle=1, rd_bram_index=0, rd_address=0, a_valid=b_valid=0.
  - Both FIFOs emptied; in-flight flag cleared.
  - Data outputs are 0.
- FSM states and transitions:
  - IDLE: idle=1. start=1 → latch bram_index_in into rd_bram_index, set rd_address=0, go to RUN.
  - RUN: issue reads (rules below). The read of address width*height-1 is issued → go to DRAIN.
  - DRAIN: no new reads. When both FIFOs are empty and nothing is in flight → IDLE.
  - idle=0 in RUN and DRAIN.
  - start is ignored outside IDLE. bram_index_in changes during a frame have no effect.
- Read issue:
  - One read per cycle maximum.
  - Issued in cycle t when state=RUN and, for each stream, occupancy + in_flight < 2.
  - rd_address increments by 1 after each issue.
  - in_flight is set for 1 cycle. At t+1, rd_data is split and pushed into both FIFOs simultaneously.
- Output buffering:
  - Each stream has its own 2-entry FIFO.
  - x_valid = FIFO non-empty; x_data = FIFO head.
  - Pop on x_valid & x_ready.
  - Streams are independent: A may run up to 2 words ahead of B and vice versa.
  - Reads stall while either FIFO would overflow.
- Throughput and latency:
  - With both readies held high, 1 word/cycle sustained.
  - First a_valid/b_valid is asserted 2 cycles after the start cycle: RUN entry +1, read +1 latency.
- Ordering: both streams emit pixels in address order 0..width*height-1, exactly once per frame. There is no frame marker.
- Payload must not change while valid=1 and ready=0.
- Boundary conditions:
  - Address wraps to 0 only via a new start.
  - Push and pop in the same cycle on a full FIFO is forbidden by the issue rule.
  - Push and pop in the same cycle on a non-full FIFO is allowed; occupancy is unchanged.
  - Asserting reset mid-frame aborts immediately. Partial data is discarded; nothing is emitted after reset deasserts until the next start.
- A new frame may start the cycle after idle rises.

Test Plan:
- width=4, height=2, BRAM model word[k]=k*0x101, bank 1, both readies high, pulse start → rd_bram_index=1; addresses 0..7 on consecutive cycles; a_data=k*0x101>>8 and b_data=(k*0x101)&0xFF for k=0..7; first valid at start+2; idle=1 after last beat.
- Same setup, b_ready=0 for the first 10 cycles, a_ready=1 → A emits words 0,1 then stalls (max 2 ahead); rd_address stops at 2; after b_ready=1, all 8 words are delivered on both streams in order.
- Random independent a_ready/b_ready toggling over a 120×240 frame → exactly 28800 beats per stream, in order, no payload change while stalled.
- Pulse start again mid-frame with bram_index_in toggled → ignored; rd_bram_index stays constant; the frame completes normally.
- Reset asserted at word 3 of an 8-word frame → idle=1, valids=0 immediately; a subsequent start replays from address 0.
- Back-to-back: start on the cycle idle rises, bank 0 then bank 1 → second frame begins cleanly; rd_bram_index switches to 1 only at the second start.

Source files
------------

// File: rtl/bram_reader_2in_split_if.sv
// bram_reader_2in_split_if: start/idle control, BRAM read port and A/B output streams of the BRAM reader
interface bram_reader_2in_split_if #(
  parameter int width = 120,
  parameter int height = 240,
  parameter int a_width = 13,
  parameter int b_width = 8
);
  localparam int addr_w = $clog2(width * height);
  logic start, bram_index_in, idle, rd_bram_index;
  logic [addr_w-1:0] rd_address;
  logic [a_width+b_width-1:0] rd_data;
  logic [a_width-1:0] a_data;
  logic a_valid, a_ready;
  logic [b_width-1:0] b_data;
  logic b_valid, b_ready;
  modport master (
    input start, bram_index_in, rd_data, a_ready, b_ready,
    output idle, rd_bram_index, rd_address, a_data, a_valid, b_data, b_valid
  );
  modport slave (
    output start, bram_index_in, rd_data, a_ready, b_ready,
    input idle, rd_bram_index, rd_address, a_data, a_valid, b_data, b_valid
  );
endinterface

// File: rtl/bram_reader_2in_split.sv
// bram_reader_2in_split: replays one frame from a ping-pong BRAM bank as stream A (upper field) and stream B (lower field); ports: clk, reset (async active-low), bus (start/idle, BRAM read port, A/B streams)
module bram_reader_2in_split #(
  parameter int width = 120,
  parameter int height = 240,
  parameter int a_width = 13,
  parameter int b_width = 8
) (
  input logic clk,
  input logic reset,
  bram_reader_2in_split_if.master bus
);
  localparam int addr_w = $clog2(width * height);
  localparam logic [addr_w-1:0] last = addr_w'(width * height - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic bank_q, bank_d, fly_q, fly_d, issue, a_pop, b_pop;
  logic [addr_w-1:0] addr_q, addr_d;
  logic [1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, a_lvl, b_lvl;
  logic [a_width-1:0] a0_q, a0_d, a1_q, a1_d, a_in;
  logic [b_width-1:0] b0_q, b0_d, b1_q, b1_d, b_in;
  always_comb begin
    a_in = bus.rd_data[a_width+b_width-1:b_width];
    b_in = bus.rd_data[b_width-1:0];
    a_pop = a_cnt_q != 2'd0 && bus.a_ready;
    b_pop = b_cnt_q != 2'd0 && bus.b_ready;
    a_lvl = a_cnt_q - {1'b0, a_pop};
    b_lvl = b_cnt_q - {1'b0, b_pop};
    issue = state_q == RUN && a_lvl + {1'b0, fly_q} < 2'd2 && b_lvl + {1'b0, fly_q} < 2'd2;
    fly_d = issue;
    addr_d = state_q == IDLE && bus.start ? '0 : issue ? addr_q + addr_w'(1) : addr_q;
    bank_d = state_q == IDLE && bus.start ? bus.bram_index_in : bank_q;
    state_d = state_q == IDLE ? (bus.start ? RUN : IDLE)
            : state_q == RUN ? (issue && addr_q == last ? DRAIN : RUN)
            : (a_cnt_q == 2'd0 && b_cnt_q == 2'd0 && !fly_q ? IDLE : DRAIN);
    a_cnt_d = a_lvl + {1'b0, fly_q};
    b_cnt_d = b_lvl + {1'b0, fly_q};
    a0_d = fly_q && a_lvl == 2'd0 ? a_in : a_pop ? a1_q : a0_q;
    a1_d = fly_q && a_lvl == 2'd1 ? a_in : a1_q;
    b0_d = fly_q && b_lvl == 2'd0 ? b_in : b_pop ? b1_q : b0_q;
    b1_d = fly_q && b_lvl == 2'd1 ? b_in : b1_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bank_q <= 1'b0;
      fly_q <= 1'b0;
      addr_q <= '0;
      a_cnt_q <= 2'd0;
      b_cnt_q <= 2'd0;
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_d;
      fly_q <= fly_d;
      addr_q <= addr_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      a0_q <= a0_d;
      a1_q <= a1_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
    end
  end
  assign bus.idle = state_q == IDLE;
  assign bus.rd_bram_index = bank_q;
  assign bus.rd_address = addr_q;
  assign bus.a_valid = a_cnt_q != 2'd0;
  assign bus.a_data = a0_q;
  assign bus.b_valid = b_cnt_q != 2'd0;
  assign bus.b_data = b0_q;
endmodule

// File: tb/tb_bram_reader_2in_split.sv
// tb_bram_reader_2in_split: directed checks of the BRAM reader on a 4x2 frame plus a randomly throttled 120x240 frame
module tb_bram_reader_2in_split;
  localparam int lw = 120 * 240;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0, n_err = 0;
  int a_idx, b_idx, la, lb;
  logic exp_bank;
  logic a_stall, b_stall, la_stall, lb_stall;
  logic [12:0] a_hold, la_hold;
  logic [7:0] b_hold, lb_hold;
  always #5 clk = ~clk;
  bram_reader_2in_split_if #(.width(4), .height(2)) s_if();
  bram_reader_2in_split_if #(.width(120), .height(240)) l_if();
  bram_reader_2in_split #(.width(4), .height(2)) dut_s (.clk(clk), .reset(reset), .bus(s_if));
  bram_reader_2in_split #(.width(120), .height(240)) dut_l (.clk(clk), .reset(reset), .bus(l_if));
  function automatic logic [20:0] sword(input logic bank, input int k);
    return bank ? 21'(k * 'h101) : 21'(k * 'h202 + 'h10000);
  endfunction
  function automatic logic [20:0] lword(input logic bank, input int k);
    return 21'(k * 40503 + 7) ^ 21'(bank);
  endfunction
  always @(posedge clk) s_if.rd_data <= sword(s_if.rd_bram_index, int'(s_if.rd_address));
  always @(posedge clk) l_if.rd_data <= lword(l_if.rd_bram_index, int'(l_if.rd_address));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    logic [20:0] w;
    if (a_stall && s_if.a_valid) chk("a_hold", s_if.a_data, a_hold);
    if (b_stall && s_if.b_valid) chk("b_hold", s_if.b_data, b_hold);
    if (s_if.a_valid && s_if.a_ready) begin
      w = sword(exp_bank, a_idx);
      chk("a_beat", s_if.a_data, w[20:8]);
      a_idx++;
    end
    if (s_if.b_valid && s_if.b_ready) begin
      w = sword(exp_bank, b_idx);
      chk("b_beat", s_if.b_data, w[7:0]);
      b_idx++;
    end
    a_stall = s_if.a_valid && !s_if.a_ready;
    b_stall = s_if.b_valid && !s_if.b_ready;
    a_hold = s_if.a_data;
    b_hold = s_if.b_data;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic lcheck();
    logic [20:0] w;
    if (la_stall && l_if.a_valid) chk("la_hold", l_if.a_data, la_hold);
    if (lb_stall && l_if.b_valid) chk("lb_hold", l_if.b_data, lb_hold);
    if (l_if.a_valid && l_if.a_ready) begin
      w = lword(1'b0, la);
      chk("la_beat", l_if.a_data, w[20:8]);
      la++;
    end
    if (l_if.b_valid && l_if.b_ready) begin
      w = lword(1'b0, lb);
      chk("lb_beat", l_if.b_data, w[7:0]);
      lb++;
    end
    la_stall = l_if.a_valid && !l_if.a_ready;
    lb_stall = l_if.b_valid && !l_if.b_ready;
    la_hold = l_if.a_data;
    lb_hold = l_if.b_data;
  endtask
  task automatic go(input logic bank);
    s_if.bram_index_in = bank;
    s_if.start = 1'b1;
    cyc();
    s_if.start = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    for (int c = 0; c < lim && !s_if.idle; c++) cyc();
    chk("idle_bound", s_if.idle, 1);
  endtask
  initial begin
    s_if.start = 1'b0;
    s_if.bram_index_in = 1'b0;
    s_if.a_ready = 1'b1;
    s_if.b_ready = 1'b1;
    l_if.start = 1'b0;
    l_if.bram_index_in = 1'b0;
    l_if.a_ready = 1'b1;
    l_if.b_ready = 1'b1;
    a_idx = 0; b_idx = 0; la = 0; lb = 0; exp_bank = 1'b0;
    a_stall = 1'b0; b_stall = 1'b0; la_stall = 1'b0; lb_stall = 1'b0;
    a_hold = '0; b_hold = '0; la_hold = '0; lb_hold = '0;
    @(negedge clk);
    cyc();
    chk("rst_idle", s_if.idle, 1);
    chk("rst_a_valid", s_if.a_valid, 0);
    chk("rst_b_valid", s_if.b_valid, 0);
    chk("rst_addr", s_if.rd_address, 0);
    chk("rst_bank", s_if.rd_bram_index, 0);
    chk("rst_a_data", s_if.a_data, 0);
    chk("rst_b_data", s_if.b_data, 0);
    reset = 1'b1;
    cyc();
    exp_bank = 1'b1; a_idx = 0; b_idx = 0;
    go(1'b1);
    chk("t1_bank", s_if.rd_bram_index, 1);
    chk("t1_busy", s_if.idle, 0);
    chk("t1_addr0", s_if.rd_address, 0);
    chk("t1_valid_e0", s_if.a_valid, 0);
    cyc();
    chk("t1_valid_e1", s_if.a_valid, 0);
    chk("t1_addr1", s_if.rd_address, 1);
    cyc();
    chk("t1_a_first", s_if.a_valid, 1);
    chk("t1_b_first", s_if.b_valid, 1);
    chk("t1_addr2", s_if.rd_address, 2);
    for (int k = 3; k < 8; k++) begin
      cyc();
      chk("t1_addr", s_if.rd_address, k);
    end
    wait_idle(20);
    chk("t1_a_count", a_idx, 8);
    chk("t1_b_count", b_idx, 8);
    a_idx = 0; b_idx = 0;
    s_if.b_ready = 1'b0;
    go(1'b1);
    repeat (9) cyc();
    chk("t2_addr_stall", s_if.rd_address, 2);
    chk("t2_a_ahead", a_idx, 2);
    chk("t2_b_none", b_idx, 0);
    chk("t2_a_empty", s_if.a_valid, 0);
    chk("t2_b_held", s_if.b_valid, 1);
    s_if.b_ready = 1'b1;
    wait_idle(40);
    chk("t2_a_count", a_idx, 8);
    chk("t2_b_count", b_idx, 8);
    exp_bank = 1'b0; a_idx = 0; b_idx = 0;
    go(1'b0);
    repeat (3) cyc();
    s_if.bram_index_in = 1'b1;
    s_if.start = 1'b1;
    cyc();
    s_if.start = 1'b0;
    chk("t3_bank_mid", s_if.rd_bram_index, 0);
    wait_idle(40);
    chk("t3_a_count", a_idx, 8);
    chk("t3_b_count", b_idx, 8);
    chk("t3_bank_end", s_if.rd_bram_index, 0);
    exp_bank = 1'b1; a_idx = 0; b_idx = 0;
    go(1'b1);
    for (int c = 0; c < 20 && a_idx < 3; c++) cyc();
    chk("t4_reached", a_idx, 3);
    reset = 1'b0;
    #1;
    chk("t4_idle_now", s_if.idle, 1);
    chk("t4_a_drop", s_if.a_valid, 0);
    chk("t4_b_drop", s_if.b_valid, 0);
    cyc();
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    chk("t4_idle_after", s_if.idle, 1);
    chk("t4_a_quiet", s_if.a_valid, 0);
    chk("t4_b_quiet", s_if.b_valid, 0);
    chk("t4_addr", s_if.rd_address, 0);
    chk("t4_no_emit", a_idx, 3);
    a_idx = 0; b_idx = 0;
    go(1'b1);
    wait_idle(20);
    chk("t4_a_replay", a_idx, 8);
    chk("t4_b_replay", b_idx, 8);
    exp_bank = 1'b0; a_idx = 0; b_idx = 0;
    go(1'b0);
    wait_idle(20);
    chk("t5_a_count0", a_idx, 8);
    chk("t5_b_count0", b_idx, 8);
    chk("t5_bank0", s_if.rd_bram_index, 0);
    exp_bank = 1'b1; a_idx = 0; b_idx = 0;
    go(1'b1);
    chk("t5_bank1", s_if.rd_bram_index, 1);
    chk("t5_busy", s_if.idle, 0);
    wait_idle(20);
    chk("t5_a_count1", a_idx, 8);
    chk("t5_b_count1", b_idx, 8);
    l_if.start = 1'b1;
    cyc();
    l_if.start = 1'b0;
    for (int c = 0; c < 90000 && !l_if.idle; c++) begin
      l_if.a_ready = $urandom_range(0, 7) != 0;
      l_if.b_ready = $urandom_range(0, 7) != 0;
      lcheck();
      cyc();
    end
    chk("l_idle", l_if.idle, 1);
    chk("l_a_count", la, lw);
    chk("l_b_count", lb, lw);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
